// File: rtl/timepulse_seq.sv
// timepulse_seq: one-hot timepulse/phase sequencer with GOJAM restart,
// monitor stop and single-MCT stepping, standby, and an overflow strobe.
module timepulse_seq #(
  parameter int NT        = 12,
  parameter int NPH       = 4,
  parameter int JAM_TICKS = 48,
  parameter int OVF_T     = 6,
  parameter int OVF_PH    = 0
) (
  input  logic           SIM_CLK,
  input  logic           SIM_RST,
  input  logic           TICK,
  input  logic           START,
  input  logic           GOJ,
  input  logic           SBY,
  input  logic           MSTP,
  input  logic           MSTRTP,
  input  logic [1:0]     WL,
  output logic [NT-1:0]  T,
  output logic [NPH-1:0] PHASE,
  output logic           GOJAM,
  output logic           STOP,
  output logic           RUN,
  output logic           MCT_END,
  output logic           OVF,
  output logic           UNF
);

  localparam int TW = (NT > 1) ? $clog2(NT) : 1;
  localparam int PW = (NPH > 1) ? $clog2(NPH) : 1;
  localparam int CW = $clog2(JAM_TICKS + 1);

  localparam logic [TW-1:0]  T_LAST   = TW'(NT - 1);
  localparam logic [PW-1:0]  PH_LAST  = PW'(NPH - 1);
  localparam logic [TW-1:0]  T_STROBE = TW'(OVF_T);
  localparam logic [PW-1:0]  PH_STROBE = PW'(OVF_PH);
  localparam logic [CW-1:0]  JAM_LOAD = CW'(JAM_TICKS);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [NT-1:0]  T_ONE    = NT'(1);
  localparam logic [NPH-1:0] PH_ONE   = NPH'(1);

  typedef enum logic [1:0] {S_JAM, S_RUN, S_HALT, S_STBY} state_t;

  state_t         state, state_n;
  logic [TW-1:0]  t, t_n;
  logic [PW-1:0]  ph, ph_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           credit, credit_n;
  logic           mstrtp_q;
  logic           advance;
  logic           restart;
  logic           at_last;
  logic           step_edge;
  logic           strobe;
  logic [NT-1:0]  t_out_n;
  logic [NPH-1:0] ph_out_n;
  logic           mct_n;
  logic           ovf_n;
  logic           unf_n;

  // Next-state, next-position and next-output decode; SBY on a TICK wins over
  // a restart request, which in turn wins over monitor stop.
  always_comb begin
    state_n   = state;
    t_n       = t;
    ph_n      = ph;
    cnt_n     = cnt;
    credit_n  = credit;
    advance   = 1'b0;
    restart   = START | GOJ;
    at_last   = (t == T_LAST) && (ph == PH_LAST);
    step_edge = MSTRTP & ~mstrtp_q;

    case (state)
      S_JAM: begin
        if (TICK && SBY) begin
          state_n = S_STBY;
        end else if (restart) begin
          cnt_n = JAM_LOAD;
        end else if (TICK) begin
          if (cnt <= CNT_ONE) begin
            cnt_n   = '0;
            state_n = S_RUN;
          end else begin
            cnt_n = cnt - CNT_ONE;
          end
        end
      end
      S_RUN: begin
        if (TICK && SBY) begin
          state_n = S_STBY;
        end else if (restart) begin
          state_n = S_JAM;
          cnt_n   = JAM_LOAD;
        end else if (TICK) begin
          if (at_last && MSTP) begin
            state_n = S_HALT;
          end else begin
            advance = 1'b1;
          end
        end
      end
      S_HALT: begin
        if (step_edge) begin
          credit_n = 1'b1;
        end
        if (TICK && SBY) begin
          state_n = S_STBY;
        end else if (restart) begin
          state_n = S_JAM;
          cnt_n   = JAM_LOAD;
        end else if (TICK && (!MSTP || credit)) begin
          state_n = S_RUN;
          advance = 1'b1;
        end
      end
      S_STBY: begin
        if (TICK && !SBY) begin
          state_n = S_JAM;
          cnt_n   = JAM_LOAD;
        end
      end
      default: begin
        state_n = S_JAM;
        cnt_n   = JAM_LOAD;
      end
    endcase

    // A step credit only lives while halted.
    if (state_n != S_HALT) begin
      credit_n = 1'b0;
    end

    // JAM and standby park the counters on the last position so the first
    // advance afterwards lands on (0, 0).
    if (state_n == S_JAM || state_n == S_STBY) begin
      t_n  = T_LAST;
      ph_n = PH_LAST;
    end

    if (advance) begin
      if (ph == PH_LAST) begin
        ph_n = '0;
        t_n  = (t == T_LAST) ? '0 : t + TW'(1);
      end else begin
        ph_n = ph + PW'(1);
      end
    end

    strobe   = advance && (t_n == T_STROBE) && (ph_n == PH_STROBE);
    mct_n    = advance && (t_n == T_LAST) && (ph_n == PH_LAST);
    ovf_n    = strobe && (WL == 2'b01);
    unf_n    = strobe && (WL == 2'b10);
    t_out_n  = (state_n == S_STBY) ? '0 : (T_ONE << t_n);
    ph_out_n = (state_n == S_STBY) ? '0 : (PH_ONE << ph_n);
  end

  // State, counters and all outputs registered together, reset to the JAM state.
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      state    <= S_JAM;
      t        <= T_LAST;
      ph       <= PH_LAST;
      cnt      <= JAM_LOAD;
      credit   <= 1'b0;
      mstrtp_q <= 1'b0;
      T        <= T_ONE << T_LAST;
      PHASE    <= PH_ONE << PH_LAST;
      GOJAM    <= 1'b1;
      STOP     <= 1'b0;
      RUN      <= 1'b0;
      MCT_END  <= 1'b0;
      OVF      <= 1'b0;
      UNF      <= 1'b0;
    end else begin
      state    <= state_n;
      t        <= t_n;
      ph       <= ph_n;
      cnt      <= cnt_n;
      credit   <= credit_n;
      mstrtp_q <= MSTRTP;
      T        <= t_out_n;
      PHASE    <= ph_out_n;
      GOJAM    <= (state_n == S_JAM);
      STOP     <= (state_n == S_HALT) || (state_n == S_STBY);
      RUN      <= (state_n == S_RUN);
      MCT_END  <= mct_n;
      OVF      <= ovf_n;
      UNF      <= unf_n;
    end
  end

endmodule

// File: tb/tb_timepulse_seq.sv
// Testbench for timepulse_seq: a default 12x4 instance and an 8x2 instance
// share all inputs and are both tracked by a linear-position reference model.
module tb_timepulse_seq;

  localparam int JT = 48;

  logic        SIM_CLK = 1'b0;
  logic        SIM_RST;
  logic        TICK;
  logic        START;
  logic        GOJ;
  logic        SBY;
  logic        MSTP;
  logic        MSTRTP;
  logic [1:0]  WL;

  logic [11:0] t_a;
  logic [3:0]  ph_a;
  logic        gojam_a, stop_a, run_a, mct_a, ovf_a, unf_a;
  logic [7:0]  t_b;
  logic [1:0]  ph_b;
  logic        gojam_b, stop_b, run_b, mct_b, ovf_b, unf_b;

  int    n_cmp = 0;
  int    n_bad = 0;
  string phase_name = "init";

  timepulse_seq dut_a (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .TICK(TICK), .START(START),
    .GOJ(GOJ), .SBY(SBY), .MSTP(MSTP), .MSTRTP(MSTRTP), .WL(WL),
    .T(t_a), .PHASE(ph_a), .GOJAM(gojam_a), .STOP(stop_a), .RUN(run_a),
    .MCT_END(mct_a), .OVF(ovf_a), .UNF(unf_a)
  );

  timepulse_seq #(.NT(8), .NPH(2)) dut_b (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .TICK(TICK), .START(START),
    .GOJ(GOJ), .SBY(SBY), .MSTP(MSTP), .MSTRTP(MSTRTP), .WL(WL),
    .T(t_b), .PHASE(ph_b), .GOJAM(gojam_b), .STOP(stop_b), .RUN(run_b),
    .MCT_END(mct_b), .OVF(ovf_b), .UNF(unf_b)
  );

  // Free-running simulation clock.
  always #5 SIM_CLK = ~SIM_CLK;

  // Reference model: the position is a single index 0..NT*NPH-1.
  typedef enum int {M_JAM, M_RUN, M_HALT, M_STBY} mstate_e;
  int      m_nt[2]  = '{12, 8};
  int      m_nph[2] = '{4, 2};
  mstate_e m_st[2];
  int      m_pos[2];
  int      m_cnt[2];
  bit      m_credit[2], m_prev[2], m_mct[2], m_ovf[2], m_unf[2];

  task automatic model_reset(input int k);
    m_st[k]     = M_JAM;
    m_pos[k]    = m_nt[k] * m_nph[k] - 1;
    m_cnt[k]    = JT;
    m_credit[k] = 1'b0;
    m_prev[k]   = 1'b0;
    m_mct[k]    = 1'b0;
    m_ovf[k]    = 1'b0;
    m_unf[k]    = 1'b0;
  endtask

  task automatic model_edge(input int k);
    int last  = m_nt[k] * m_nph[k] - 1;
    bit rq    = START || GOJ;
    bit step  = MSTRTP && !m_prev[k];
    bit held  = m_credit[k];
    bit moved = 1'b0;
    m_mct[k] = 1'b0;
    m_ovf[k] = 1'b0;
    m_unf[k] = 1'b0;
    if (TICK && SBY && m_st[k] != M_STBY) begin
      m_st[k] = M_STBY;
    end else begin
      case (m_st[k])
        M_STBY: if (TICK && !SBY) begin m_st[k] = M_JAM; m_cnt[k] = JT; end
        M_JAM: begin
          if (rq) m_cnt[k] = JT;
          else if (TICK) begin
            m_cnt[k] = m_cnt[k] - 1;
            if (m_cnt[k] == 0) m_st[k] = M_RUN;
          end
        end
        M_RUN: begin
          if (rq) begin m_st[k] = M_JAM; m_cnt[k] = JT; end
          else if (TICK) begin
            if (m_pos[k] == last && MSTP) m_st[k] = M_HALT;
            else moved = 1'b1;
          end
        end
        M_HALT: begin
          if (step) m_credit[k] = 1'b1;
          if (rq) begin m_st[k] = M_JAM; m_cnt[k] = JT; end
          else if (TICK && (!MSTP || held)) begin m_st[k] = M_RUN; moved = 1'b1; end
        end
        default: ;
      endcase
    end
    if (m_st[k] != M_HALT) m_credit[k] = 1'b0;
    if (m_st[k] == M_JAM || m_st[k] == M_STBY) m_pos[k] = last;
    if (moved) begin
      m_pos[k] = (m_pos[k] + 1) % (last + 1);
      m_mct[k] = (m_pos[k] == last);
      if (m_pos[k] == 6 * m_nph[k]) begin
        m_ovf[k] = (WL == 2'b01);
        m_unf[k] = (WL == 2'b10);
      end
    end
    m_prev[k] = MSTRTP;
  endtask

  // Compares every output of both instances against the model.
  task automatic checkOutput(input string name);
    int got, want, tv, pv, fl;
    for (int k = 0; k < 2; k++) begin
      if (k == 0)
        got = (int'(t_a) << 16) | (int'(ph_a) << 8) |
              int'({gojam_a, stop_a, run_a, mct_a, ovf_a, unf_a});
      else
        got = (int'(t_b) << 16) | (int'(ph_b) << 8) |
              int'({gojam_b, stop_b, run_b, mct_b, ovf_b, unf_b});
      tv = (m_st[k] == M_STBY) ? 0 : (1 << (m_pos[k] / m_nph[k]));
      pv = (m_st[k] == M_STBY) ? 0 : (1 << (m_pos[k] % m_nph[k]));
      fl = int'({m_st[k] == M_JAM, m_st[k] == M_HALT || m_st[k] == M_STBY,
                 m_st[k] == M_RUN, m_mct[k], m_ovf[k], m_unf[k]});
      want = (tv << 16) | (pv << 8) | fl;
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("[TB] FAIL %s dut%0d: got %07h want %07h", name, k, got, want);
      end
    end
  endtask

  task automatic check_value(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input bit tick, input bit start, input bit goj, input bit sby,
                               input bit mstp, input bit mstrtp, input logic [1:0] wl);
    TICK   = tick;
    START  = start;
    GOJ    = goj;
    SBY    = sby;
    MSTP   = mstp;
    MSTRTP = mstrtp;
    WL     = wl;
  endtask

  // One clock: model follows the edge, outputs are sampled on the falling edge.
  task automatic run_cycle();
    @(posedge SIM_CLK);
    if (SIM_RST) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_edge(0);
      model_edge(1);
    end
    @(negedge SIM_CLK);
    checkOutput(phase_name);
  endtask

  // From a sample with GOJAM=1: GOJAM must last JT ticks, then one RUN sample
  // at the last position, then (0, 0).
  task automatic expect_restart(input string name);
    int n = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    while (gojam_a && n < 300) begin
      run_cycle();
      n++;
    end
    check_value({name, "_jam_ticks"}, n, JT);
    check_value({name, "_run_at_last"}, int'({run_a, t_a, ph_a}), int'({1'b1, 12'h800, 4'h8}));
    run_cycle();
    check_value({name, "_first_pos"}, int'({t_a, ph_a}), int'({12'h001, 4'h1}));
  endtask

  typedef struct {
    bit          sby;
    bit          mstp;
    int          cycles;
    logic [11:0] t;
    logic [3:0]  ph;
    bit          gojam;
    bit          stop;
    bit          run;
  } vec_t;

  function automatic vec_t mk(input bit sby, input bit mstp, input int cyc, input logic [11:0] t,
                              input logic [3:0] ph, input bit g, input bit s, input bit r);
    vec_t v;
    v.sby = sby; v.mstp = mstp; v.cycles = cyc; v.t = t; v.ph = ph;
    v.gojam = g; v.stop = s; v.run = r;
    return v;
  endfunction

  initial begin
    vec_t vecs[$];
    int   n, c_mct, co, cu, a_first, a_second, b_first, b_second;
    bit   r_sby, r_mstp, r_step;

    // Expected trace of the default instance from reset, TICK every cycle.
    vecs.push_back(mk(1'b0, 1'b0,  0, 12'h800, 4'h8, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 47, 12'h800, 4'h8, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0,  1, 12'h800, 4'h8, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0,  1, 12'h001, 4'h1, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0,  1, 12'h001, 4'h2, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0,  3, 12'h002, 4'h1, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 25, 12'h080, 4'h2, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 18, 12'h800, 4'h8, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1,  1, 12'h800, 4'h8, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1,  5, 12'h800, 4'h8, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0,  1, 12'h001, 4'h1, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0,  1, 12'h000, 4'h0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0,  4, 12'h000, 4'h0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0,  1, 12'h800, 4'h8, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 48, 12'h800, 4'h8, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0,  1, 12'h001, 4'h1, 1'b0, 1'b0, 1'b1));

    SIM_RST = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    model_reset(0);
    model_reset(1);
    repeat (2) @(negedge SIM_CLK);
    phase_name = "reset";
    checkOutput(phase_name);
    SIM_RST = 1'b0;

    phase_name = "table";
    for (int i = 0; i < vecs.size(); i++) begin
      for (int c = 0; c < vecs[i].cycles; c++) begin
        applyStimulus(1'b1, 1'b0, 1'b0, vecs[i].sby, vecs[i].mstp, 1'b0, 2'b00);
        run_cycle();
      end
      check_value($sformatf("vec%0d_T", i), int'(t_a), int'(vecs[i].t));
      check_value($sformatf("vec%0d_PHASE", i), int'(ph_a), int'(vecs[i].ph));
      check_value($sformatf("vec%0d_flags", i), int'({gojam_a, stop_a, run_a}),
                  int'({vecs[i].gojam, vecs[i].stop, vecs[i].run}));
    end

    // Boot from reset and measure the MCT length on both instances.
    phase_name = "boot";
    SIM_RST = 1'b1;
    #1;
    model_reset(0);
    model_reset(1);
    checkOutput("reset_async_mid");
    run_cycle();
    SIM_RST = 1'b0;
    expect_restart("boot");
    a_first = -1; a_second = -1; b_first = -1; b_second = -1;
    for (int i = 1; i <= 100; i++) begin
      run_cycle();
      if (mct_a) begin if (a_first < 0) a_first = i; else if (a_second < 0) a_second = i; end
      if (mct_b) begin if (b_first < 0) b_first = i; else if (b_second < 0) b_second = i; end
    end
    check_value("mct_first_a", a_first, 47);
    check_value("mct_period_a", a_second - a_first, 48);
    check_value("mct_first_b", b_first, 15);
    check_value("mct_period_b", b_second - b_first, 16);

    // GOJ pulse at (5, 2).
    phase_name = "goj";
    n = 0;
    while (!(t_a == 12'h020 && ph_a == 4'h4) && n < 100) begin run_cycle(); n++; end
    check_value("goj_reach_5_2", int'(n < 100), 1);
    GOJ = 1'b1;
    run_cycle();
    GOJ = 1'b0;
    check_value("goj_entry", int'({gojam_a, t_a}), int'({1'b1, 12'h800}));
    expect_restart("goj");

    // Monitor stop, then one step.
    phase_name = "mstp";
    MSTP = 1'b1;
    n = 0;
    while (!stop_a && n < 100) begin run_cycle(); n++; end
    check_value("halt_pos", int'({stop_a, t_a, ph_a}), int'({1'b1, 12'h800, 4'h8}));
    MSTRTP = 1'b1;
    run_cycle();
    MSTRTP = 1'b0;
    check_value("step_wait", int'(stop_a), 1);
    run_cycle();
    n = 0;
    c_mct = 0;
    while (run_a && n < 200) begin
      n++;
      if (mct_a) c_mct++;
      run_cycle();
    end
    check_value("step_ticks", n, 48);
    check_value("step_mct", c_mct, 1);
    check_value("step_rehalt", int'({stop_a, t_a, ph_a}), int'({1'b1, 12'h800, 4'h8}));
    MSTP = 1'b0;

    // Overflow strobe for each WL pattern over one full MCT.
    phase_name = "ovf";
    for (int w = 1; w <= 3; w++) begin
      WL = 2'(w);
      co = 0;
      cu = 0;
      for (int i = 0; i < 48; i++) begin
        run_cycle();
        if (ovf_a) begin co++; check_value("ovf_pos", int'({t_a, ph_a}), int'({12'h040, 4'h1})); end
        if (unf_a) begin cu++; check_value("unf_pos", int'({t_a, ph_a}), int'({12'h040, 4'h1})); end
      end
      check_value($sformatf("ovf_count_wl%0d", w), co, (w == 1) ? 1 : 0);
      check_value($sformatf("unf_count_wl%0d", w), cu, (w == 2) ? 1 : 0);
    end
    WL = 2'b00;

    // Standby mid-MCT.
    phase_name = "sby";
    repeat (5) run_cycle();
    SBY = 1'b1;
    run_cycle();
    check_value("sby_outputs", int'({t_a, ph_a, stop_a, run_a, gojam_a}),
                int'({12'h000, 4'h0, 1'b1, 1'b0, 1'b0}));
    repeat (2) run_cycle();
    SBY = 1'b0;
    run_cycle();
    expect_restart("sby");

    // Randomized traffic checked cycle by cycle against the model.
    phase_name = "random";
    r_sby = 1'b0; r_mstp = 1'b0; r_step = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (r_sby) r_sby = ($urandom_range(0, 3) != 0);
      else       r_sby = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) r_mstp = !r_mstp;
      if ($urandom_range(0, 7) == 0)  r_step = !r_step;
      applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 249) == 0,
                    $urandom_range(0, 199) == 0, r_sby, r_mstp, r_step,
                    2'($urandom_range(0, 3)));
      run_cycle();
    end

    // TICK every third cycle, then an asynchronous reset mid-MCT.
    phase_name = "slow_tick";
    SIM_RST = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    run_cycle();
    SIM_RST = 1'b0;
    for (int i = 0; i < 200; i++) begin
      TICK = (i % 3 == 0);
      run_cycle();
    end
    check_value("slow_tick_mid_mct", int'(run_a && t_a != 12'h800), 1);
    #2;
    SIM_RST = 1'b1;
    #1;
    model_reset(0);
    model_reset(1);
    checkOutput("async_reset");
    check_value("async_reset_a", int'({t_a, ph_a, gojam_a, stop_a, run_a, mct_a, ovf_a, unf_a}),
                int'({12'h800, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
    check_value("async_reset_b", int'({t_b, ph_b, gojam_b, run_b}),
                int'({8'h80, 2'b10, 1'b1, 1'b0}));
    run_cycle();
    SIM_RST = 1'b0;
    run_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
